// File: rtl/float_divider.sv
// Sequential single-precision divider, result = a / b.
// Restoring radix-2 division produces one quotient bit per clock. Operands are
// treated as normalised, the exponent wraps modulo 256, and the mantissa is
// truncated. Zero operands are handled explicitly.
module float_divider #(
  parameter int QBITS = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, NORM} state_t;

  state_t      state_q, state_d;
  logic [24:0] rem_q, rem_d;
  logic [23:0] div_q, div_d;
  logic [24:0] q_q, q_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic        za_q, za_d;
  logic        zb_q, zb_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic        dbz_q, dbz_d;

  // Next-state, datapath step and result packing
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    div_d    = div_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    za_d     = za_q;
    zb_d     = zb_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    // busy covers the CALC edges only, so it drops in the done cycle and
    // never rises for the one-cycle zero-operand path
    busy_d   = (state_q == CALC);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d = a[31] ^ b[31];
          za_d   = (a[30:0] == 31'd0);
          zb_d   = (b[30:0] == 31'd0);
          // biased exponent for the Ma>=Mb case; NORM subtracts one otherwise
          exp_d  = a[30:23] - b[30:23] + 8'd127;
          if ((a[30:0] == 31'd0) || (b[30:0] == 31'd0)) begin
            state_d = NORM;
          end else begin
            state_d = CALC;
            rem_d   = {2'b01, a[22:0]};
            div_d   = {1'b1, b[22:0]};
            q_d     = '0;
            cnt_d   = '0;
          end
        end
      end
      CALC: begin
        // rem < 2*div always holds, so the shifted remainder fits 25 bits
        if (rem_q >= {1'b0, div_q}) begin
          rem_d = (rem_q - {1'b0, div_q}) << 1;
          q_d   = {q_q[23:0], 1'b1};
        end else begin
          rem_d = rem_q << 1;
          q_d   = {q_q[23:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(QBITS - 1)) state_d = NORM;
      end
      NORM: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (zb_q) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          dbz_d    = 1'b1;
        end else if (za_q) begin
          result_d = 32'd0;
          dbz_d    = 1'b0;
        end else if (q_q[24]) begin
          result_d = {sign_q, exp_q, q_q[23:1]};
          dbz_d    = 1'b0;
        end else begin
          result_d = {sign_q, exp_q - 8'd1, q_q[22:0]};
          dbz_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      div_q    <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      za_q     <= 1'b0;
      zb_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      za_q     <= za_d;
      zb_q     <= zb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/float_divider.md
Name: float_divider

Overview:
- Sequential IEEE-754 single-precision divider, result = a / b; the inverse operation to the team's combinational float multiplier.
- Shares the multiplier's number model: normalised operands only, truncated mantissa, 8-bit modular exponent, explicit zero handling.
- Restoring radix-2 division, one quotient bit per clock, start/busy/done handshake.
- Sits beside the multiplier in the FP datapath, in slots where a multi-cycle latency is acceptable.

Parameters:
- QBITS, 25, quotient bits produced (24-bit significand plus 1 normalisation bit); fixed, must not be changed.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when idle.
- a  input  32  dividend, IEEE-754 single.
- b  input  32  divisor, IEEE-754 single.
- busy  output  1  high while a division is in flight.
- done  output  1  one-cycle pulse; result valid.
- result  output  32  quotient; held until the next accepted start.
- div_by_zero  output  1  set with done when b is ±0; held with result.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, result=32'd0, div_by_zero=0; internal regs cleared. Reset mid-operation aborts with no done pulse.
- States: IDLE, CALC, NORM.
- Acceptance: start=1 at a rising edge while busy=0 latches a and b. done may still be high in that cycle; back-to-back is legal. start while busy=1 is ignored and the in-flight operands are untouched.
- Latch edge E: sign=a[31]^b[31]; za=(a[30:0]==0); zb=(b[30:0]==0).
  - zb or za: next state NORM.
  - Otherwise: next state CALC; rem=25-bit {1,a[22:0]}; div={1,b[22:0]}; q=0; count=0.
- CALC, each edge:
  - if rem>=div: rem<=(rem-div)<<1, q<<={q,1}.
  - else: rem<=rem<<1, q<={q,0}.
  - count increments; after the 25th CALC edge (E+25) go to NORM.
- NORM edge (E+26 normal, E+1 special): register result, pulse done=1 for one cycle, busy=0, return to IDLE.
  - zb: result={sign,8'hFF,23'd0}, div_by_zero=1. Takes priority over za.
  - za (and not zb): result=32'd0 (sign dropped), div_by_zero=0.
  - q[24]=1 (Ma>=Mb): mantissa=q[23:1]; exp=ea-eb+127.
  - q[24]=0 (Ma<Mb): mantissa=q[22:0]; exp=ea-eb+126.
  - Normal result={sign,exp,mantissa}, div_by_zero=0.
- Exponent: computed in 8 bits, wraps modulo 256; no overflow/underflow/NaN/Inf/denormal detection. Mantissa truncated, no rounding.
- busy: 1 from the edge after E up to and including the cycle before done; 0 in the done cycle.
- Latency start-to-done: 26 cycles normal, 1 cycle special.
- result and div_by_zero are stable from done until the NORM edge of the next operation.

Test Plan:
- a=0x40C00000 (6.0), b=0x40000000 (2.0), start 1 cycle -> done exactly 26 cycles after the latch edge, result=0x40400000, div_by_zero=0; busy high for 25 cycles.
- a=0x3F800000 (1.0), b=0x40400000 (3.0) -> result=0x3EAAAAAA (truncated, Ma<Mb path, exponent 0x7D).
- a=0xC0F00000 (-7.5), b=0x40200000 (2.5) -> result=0xC0400000 (-3.0); then a=0x80000000 (-0), b=0x3F800000 -> result=0x00000000, done 1 cycle after latch.
- a=0x3F800000, b=0x80000000 (-0) -> result=0xFF800000, div_by_zero=1, 1-cycle latency. a=0, b=0 -> result={0,FF,0}, div_by_zero=1.
- start pulsed again at cycle 10 of the 6.0/2.0 op with different operands -> ignored; result still 0x40400000. New start in the done cycle -> accepted, second done 26 cycles later.
- rst_n low at cycle 12 of an operation -> busy=0, done=0, result=0 immediately, no done pulse afterwards. After release, a fresh 6.0/2.0 completes normally.
